// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU AXI4-Lite initiator: FSM state encoding,
// AXI response codes and the read data returned on a watchdog timeout.
package cpu_axi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_WRESP = ST_WRESP,
    S_RADDR = ST_RADDR,
    S_RDATA = ST_RDATA,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // OKAY and EXOKAY are successes; SLVERR and DECERR are errors.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_watchdog_counter.sv
// Cycle counter bounding how long one AXI transaction may stay in flight.
// o_expired is high in the cycle whose increment reaches TIMEOUT_CYCLES.
module axi_watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_expired = i_enable && (r_count == LAST);

  // Count in-flight cycles; a new acceptance restarts the count.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_axi_master.sv
// AXI4-Lite initiator for the RISC-V load/store unit. One transaction in
// flight, all AXI outputs registered. Optional watchdog enabled by defining
// CPU_AXI_MASTER_TIMEOUT_EN; without it transactions wait indefinitely.
module cpu_axi_master
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              timeout_flag,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  // Accesses are word aligned on the bus; low address bits are dropped.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(3));

  state_t r_state;
  logic   w_accept;
  logic   w_aw_done;
  logic   w_w_done;
  logic   w_expired;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  // A channel is finished once its VALID is already low or handshakes now.
  assign w_aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

`ifdef CPU_AXI_MASTER_TIMEOUT_EN
  logic w_wd_en;

  assign w_wd_en = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                   (r_state == S_RADDR) || (r_state == S_RDATA);

  axi_watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_enable (w_wd_en),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Handshake FSM driving every registered request-side and AXI output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      busy          <= 1'b0;
      timeout_flag  <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (w_expired) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        resp_err      <= 1'b1;
        resp_rdata    <= TIMEOUT_RDATA;
        timeout_flag  <= 1'b1;
        busy          <= 1'b0;
        resp_valid    <= 1'b1;
        r_state       <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              req_ready   <= 1'b0;
              busy        <= 1'b1;
              M_AXI_WDATA <= req_wdata;
              M_AXI_WSTRB <= req_wstrb;
              if (req_we) begin
                M_AXI_AWADDR  <= req_addr & ADDR_MASK;
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                r_state       <= S_WRITE;
              end else begin
                M_AXI_ARADDR  <= req_addr & ADDR_MASK;
                M_AXI_ARVALID <= 1'b1;
                r_state       <= S_RADDR;
              end
            end
          end
          S_WRITE: begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
            if (w_aw_done && w_w_done) begin
              M_AXI_BREADY <= 1'b1;
              r_state      <= S_WRESP;
            end
          end
          S_WRESP: begin
            if (M_AXI_BVALID) begin
              resp_err     <= resp_is_err(M_AXI_BRESP);
              resp_rdata   <= '0;
              M_AXI_BREADY <= 1'b0;
              busy         <= 1'b0;
              resp_valid   <= 1'b1;
              r_state      <= S_DONE;
            end
          end
          S_RADDR: begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              r_state       <= S_RDATA;
            end
          end
          S_RDATA: begin
            if (M_AXI_RVALID) begin
              resp_rdata   <= M_AXI_RDATA;
              resp_err     <= resp_is_err(M_AXI_RRESP);
              M_AXI_RREADY <= 1'b0;
              busy         <= 1'b0;
              resp_valid   <= 1'b1;
              r_state      <= S_DONE;
            end
          end
          S_DONE: begin
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
          default: begin
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Self-checking bench for cpu_axi_master: table of transactions against a
// scripted AXI slave, plus hand-written back-to-back, reset and timeout cases.
module tb_cpu_axi_master;
  import cpu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err, busy, timeout_flag;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  cpu_axi_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .timeout_flag(timeout_flag),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [1:0]  rsp;
    logic [31:0] rdat;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
  endtask

  // Issue one request and play the slave side; called just after a negedge.
  task automatic do_txn(input vec_t v, input bit keep, output int waited);
    int   awhs, whs, bhs, arhs, rhs, bstart, rstart;
    bit   got;
    exp_t e;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdat; req_wstrb = v.strb;
    bresp = v.rsp; rresp = v.rsp; rdata = v.rdat;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    awhs = 0; whs = 0; bhs = 0; arhs = 0; rhs = 0; bstart = 0; rstart = 0;
    got = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) @(negedge clk);
      check("aw_ar_overlap", 32'(awvalid & arvalid), 32'd0);
      if (resp_valid) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 32'(c), 32'(e.lat));
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
        end
        check("busy_at_done", 32'(busy), 32'd0);
        check("ready_at_done", 32'(req_ready), 32'd0);
        break;
      end
      check("busy", 32'(busy), 32'd1);
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("awvalid", 32'(awvalid), 32'(v.we && awhs == 0));
      check("wvalid", 32'(wvalid), 32'(v.we && whs == 0));
      check("arvalid", 32'(arvalid), 32'(!v.we && arhs == 0));
      if (awvalid) check("awaddr", awaddr, v.exp_addr);
      if (wvalid) begin
        check("wdata", wdata, v.wdat);
        check("wstrb", 32'(wstrb), 32'(v.strb));
      end
      if (arvalid) check("araddr", araddr, v.exp_addr);
      if (bready && bstart == 0) bstart = c;
      if (rready && rstart == 0) rstart = c;
      awready = v.we && (c >= 1 + v.aw_d);
      wready  = v.we && (c >= 1 + v.w_d);
      arready = !v.we && (c >= 1 + v.ar_d);
      bvalid  = (bstart != 0) && (bhs == 0) && (c >= bstart + v.b_d);
      rvalid  = (rstart != 0) && (rhs == 0) && (c >= rstart + v.r_d);
      if (awvalid && awready) awhs++;
      if (wvalid && wready)   whs++;
      if (bvalid && bready)   bhs++;
      if (arvalid && arready) arhs++;
      if (rvalid && rready)   rhs++;
    end
    slave_idle();
    if (!got) check("resp_seen", 32'd0, 32'd1);
    if (v.we) begin
      check("aw_handshakes", 32'(awhs), 32'd1);
      check("w_handshakes", 32'(whs), 32'd1);
      check("b_handshakes", 32'(bhs), 32'd1);
    end else begin
      check("ar_handshakes", 32'(arhs), 32'd1);
      check("r_handshakes", 32'(rhs), 32'd1);
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("ready_after_done", 32'(req_ready), 32'd1);
    check("bready_after", 32'(bready), 32'd0);
    check("rready_after", 32'(rready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   w;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    bresp = RESP_OKAY; rresp = RESP_OKAY; rdata = '0;
    slave_idle();

    //          we    addr           wdata          strb  rsp          rdata          aw w  b  ar r  exp_addr       exp_rdata      err  lat
    tbl[0] = '{1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   32'h0,         0, 0, 0, 0, 0, 32'h4000_0010, 32'h0,         1'b0, 3};
    tbl[1] = '{1'b1, 32'h4000_0104, 32'h1122_3344, 4'h3, RESP_OKAY,   32'h0,         4, 0, 0, 0, 0, 32'h4000_0104, 32'h0,         1'b0, 7};
    tbl[2] = '{1'b0, 32'h4000_0022, 32'h0,         4'h0, RESP_SLVERR, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h4000_0020, 32'h1234_5678, 1'b1, 3};
    tbl[3] = '{1'b0, 32'h4000_0008, 32'h0,         4'h0, RESP_EXOKAY, 32'hA5A5_5A5A, 0, 0, 0, 2, 3, 32'h4000_0008, 32'hA5A5_5A5A, 1'b0, 8};
    tbl[4] = '{1'b1, 32'h4000_000E, 32'hDEAD_C0DE, 4'h8, RESP_DECERR, 32'h7777_7777, 1, 3, 2, 0, 0, 32'h4000_000C, 32'h0,         1'b1, 8};
    tbl[5] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, RESP_OKAY,   32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 3};
    tbl[6] = '{1'b1, 32'h4000_0200, 32'h0F0F_0F0F, 4'h5, RESP_EXOKAY, 32'h0,         0, 0, 1, 0, 0, 32'h4000_0200, 32'h0,         1'b0, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i], 1'b0, w);
      check("accept_immediate", 32'(w), 32'd0);
    end

    // Back-to-back reads with req_valid held: the second must be taken in
    // the cycle right after the first response pulse.
    v = '{1'b0, 32'h4000_0031, 32'h0, 4'h0, RESP_OKAY, 32'h0BAD_F00D, 0, 0, 0, 1, 0,
          32'h4000_0030, 32'h0BAD_F00D, 1'b0, 4};
    do_txn(v, 1'b1, w);
    check("b2b_first_wait", 32'(w), 32'd0);
    check("b2b_req_held", 32'(req_valid), 32'd1);
    do_txn(v, 1'b0, w);
    check("b2b_second_wait", 32'(w), 32'd0);

    // Reset while waiting for the write response.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0040;
    req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    slave_idle();
    check("wresp_bready", 32'(bready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_awvalid", 32'(awvalid), 32'd0);
    check("mid_rst_wvalid", 32'(wvalid), 32'd0);
    check("mid_rst_bready", 32'(bready), 32'd0);
    check("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check("mid_rst_rready", 32'(rready), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    do_txn(tbl[0], 1'b0, w);
    check("sb_drained", 32'(sb.size()), 32'd0);

`ifdef CPU_AXI_MASTER_TIMEOUT_EN
    begin
      int lat;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0050;
      req_wdata = 32'h1357_9BDF; req_wstrb = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
        if (resp_valid) begin
          lat = c;
          break;
        end
        @(negedge clk);
      end
      check("to_latency", 32'(lat), 32'd17);
      check("to_resp_err", 32'(resp_err), 32'd1);
      check("to_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("to_flag", 32'(timeout_flag), 32'd1);
      check("to_awvalid", 32'(awvalid), 32'd0);
      check("to_wvalid", 32'(wvalid), 32'd0);
      repeat (5) @(negedge clk);
      check("to_flag_sticky", 32'(timeout_flag), 32'd1);
      check("to_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("to_flag_cleared", 32'(timeout_flag), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
